// File: rtl/gpu_op_mux_fifo.sv
// Multi-producer GPU op queue: one private FIFO per producer channel feeding a single
// arbitrated, registered show-ahead output (rd_en/empty contract) tagged with its source channel.
module gpu_op_mux_fifo #(
    parameter int CHANNELS           = 2,
    parameter int DEPTH              = 16,
    parameter int DATA_WIDTH         = 32,
    parameter int ALMOST_FULL_MARGIN = 2,
    parameter int FIXED_PRIORITY     = 0,
    localparam int CH_W              = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ce,
    input  logic [CHANNELS-1:0]            wr_en,
    input  logic [CHANNELS*DATA_WIDTH-1:0] wr_data,
    output logic [CHANNELS-1:0]            full,
    output logic [CHANNELS-1:0]            almost_full,
    output logic [CHANNELS-1:0]            overflow,
    input  logic                           rd_en,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic [CH_W-1:0]                rd_channel,
    output logic                           empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(DEPTH - ALMOST_FULL_MARGIN);

    logic [DATA_WIDTH-1:0] mem_q [CHANNELS][DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q [CHANNELS];
    logic [PTR_W-1:0]      wr_ptr_d [CHANNELS];
    logic [PTR_W-1:0]      rd_ptr_q [CHANNELS];
    logic [PTR_W-1:0]      rd_ptr_d [CHANNELS];
    logic [CNT_W-1:0]      count_q  [CHANNELS];
    logic [CNT_W-1:0]      count_d  [CHANNELS];
    logic [CHANNELS-1:0]   full_q, full_d;
    logic [CHANNELS-1:0]   almost_full_q, almost_full_d;
    logic [CHANNELS-1:0]   overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [CH_W-1:0]       rd_channel_q, rd_channel_d;
    logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic                  empty_q, empty_d;

    logic [CHANNELS-1:0]   nonempty;
    logic [CHANNELS-1:0]   push;
    logic [CHANNELS-1:0]   pop;
    logic [CHANNELS-1:0]   grant;
    logic [CHANNELS-1:0]   hi_sel;
    logic [CHANNELS-1:0]   any_sel;
    logic                  hi_found;
    logic [CH_W-1:0]       grant_idx;
    logic [DATA_WIDTH-1:0] head;
    logic                  out_free;
    logic                  load;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            nonempty[i] = (count_q[i] != '0);
        end
    end

    // Descending scan: the last hit is the lowest index, either overall or above the RR pointer.
    always_comb begin
        hi_sel   = '0;
        any_sel  = '0;
        hi_found = 1'b0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (nonempty[i]) begin
                any_sel    = '0;
                any_sel[i] = 1'b1;
                if (FIXED_PRIORITY == 0 && CH_W'(i) > rr_ptr_q) begin
                    hi_sel    = '0;
                    hi_sel[i] = 1'b1;
                    hi_found  = 1'b1;
                end
            end
        end
        grant = hi_found ? hi_sel : any_sel;
    end

    always_comb begin
        grant_idx = '0;
        head      = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant[i]) begin
                grant_idx = CH_W'(i);
                head      = mem_q[i][rd_ptr_q[i]];
            end
        end
    end

    assign out_free = empty_q || rd_en;
    assign load     = ce && out_free && (|nonempty);

    // Flags follow the post-edge count, so a same-cycle pop never opens room for a push into a full FIFO.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            push[i]          = ce && wr_en[i] && !full_q[i];
            pop[i]           = load && grant[i];
            wr_ptr_d[i]      = wr_ptr_q[i] + PTR_W'(push[i]);
            rd_ptr_d[i]      = rd_ptr_q[i] + PTR_W'(pop[i]);
            count_d[i]       = count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            full_d[i]        = (count_d[i] == CNT_FULL);
            almost_full_d[i] = (count_d[i] >= CNT_AF);
            overflow_d[i]    = overflow_q[i] | (ce && wr_en[i] && full_q[i]);
        end
    end

    always_comb begin
        empty_d      = empty_q;
        rd_data_d    = rd_data_q;
        rd_channel_d = rd_channel_q;
        rr_ptr_d     = rr_ptr_q;
        if (ce && out_free) begin
            empty_d = !load;
            if (load) begin
                rd_data_d    = head;
                rd_channel_d = grant_idx;
                rr_ptr_d     = grant_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            full_q        <= '0;
            almost_full_q <= '0;
            overflow_q    <= '0;
            rd_data_q     <= '0;
            rd_channel_q  <= '0;
            rr_ptr_q      <= CH_W'(CHANNELS - 1);
            empty_q       <= 1'b1;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                count_q[i]  <= count_d[i];
            end
            full_q        <= full_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
            rd_data_q     <= rd_data_d;
            rd_channel_q  <= rd_channel_d;
            rr_ptr_q      <= rr_ptr_d;
            empty_q       <= empty_d;
        end
    end

    // Storage carries data only; validity is tracked entirely by the pointers and counts.
    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= wr_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign full        = full_q;
    assign almost_full = almost_full_q;
    assign overflow    = overflow_q;
    assign rd_data     = rd_data_q;
    assign rd_channel  = (CHANNELS > 1) ? rd_channel_q : '0;
    assign empty       = empty_q;

endmodule

// File: tb/tb_gpu_op_mux_fifo.sv
// Bench for gpu_op_mux_fifo: a round-robin and a fixed-priority instance share stimulus and are
// compared against a queue-based reference model of per-channel FIFOs plus one output slot.
module tb_gpu_op_mux_fifo;
    localparam int NCH   = 2;
    localparam int DEPTH = 16;
    localparam int DW    = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ce = 1'b0;
    logic rd_en = 1'b0;
    logic [NCH-1:0] wr_en = '0;
    logic [NCH*DW-1:0] wr_data = '0;

    logic [NCH-1:0] full_r, af_r, ovf_r, full_f, af_f, ovf_f;
    logic [DW-1:0] data_r, data_f;
    logic [0:0] ch_r, ch_f;
    logic empty_r, empty_f;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    gpu_op_mux_fifo #(.CHANNELS(NCH), .DEPTH(DEPTH), .DATA_WIDTH(DW),
                      .ALMOST_FULL_MARGIN(2), .FIXED_PRIORITY(0)) u_rr (
        .clk(clk), .rst(rst), .ce(ce), .wr_en(wr_en), .wr_data(wr_data),
        .full(full_r), .almost_full(af_r), .overflow(ovf_r), .rd_en(rd_en),
        .rd_data(data_r), .rd_channel(ch_r), .empty(empty_r));

    gpu_op_mux_fifo #(.CHANNELS(NCH), .DEPTH(DEPTH), .DATA_WIDTH(DW),
                      .ALMOST_FULL_MARGIN(2), .FIXED_PRIORITY(1)) u_fp (
        .clk(clk), .rst(rst), .ce(ce), .wr_en(wr_en), .wr_data(wr_data),
        .full(full_f), .almost_full(af_f), .overflow(ovf_f), .rd_en(rd_en),
        .rd_data(data_f), .rd_channel(ch_f), .empty(empty_f));

    // Reference model: instance m (0 = round-robin, 1 = fixed priority), channel c at mq[m*NCH+c].
    logic [DW-1:0] mq [2*NCH][$];
    bit            mval  [2];
    logic [DW-1:0] mdata [2];
    int            mch   [2];
    int            mlast [2];
    bit            movf  [2*NCH];

    task automatic model_reset();
        for (int i = 0; i < 2*NCH; i++) begin
            mq[i].delete();
            movf[i] = 1'b0;
        end
        for (int m = 0; m < 2; m++) begin
            mval[m]  = 1'b0;
            mdata[m] = '0;
            mch[m]   = 0;
            mlast[m] = NCH - 1;
        end
    endtask

    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            int g;
            bit acc [NCH];
            g = -1;
            if (ce) begin
                if (!mval[m] || rd_en) begin
                    if (m == 0) begin
                        for (int k = 1; k <= NCH; k++)
                            if (g < 0 && mq[m*NCH + (mlast[m] + k) % NCH].size() > 0)
                                g = (mlast[m] + k) % NCH;
                    end else begin
                        for (int c = NCH - 1; c >= 0; c--)
                            if (mq[m*NCH + c].size() > 0) g = c;
                    end
                    if (g < 0) mval[m] = 1'b0;
                end
                for (int c = 0; c < NCH; c++) begin
                    acc[c] = wr_en[c] && (mq[m*NCH + c].size() < DEPTH);
                    if (wr_en[c] && !acc[c]) movf[m*NCH + c] = 1'b1;
                end
                if (g >= 0) begin
                    mdata[m] = mq[m*NCH + g].pop_front();
                    mch[m]   = g;
                    mval[m]  = 1'b1;
                    mlast[m] = g;
                end
                for (int c = 0; c < NCH; c++)
                    if (acc[c]) mq[m*NCH + c].push_back(wr_data[c*DW +: DW]);
            end
        end
    endtask

    // Packed as {empty, rd_data, rd_channel, full, almost_full, overflow}.
    function automatic logic [39:0] exp_vec(int m);
        logic [NCH-1:0] f, a, o;
        for (int c = 0; c < NCH; c++) begin
            f[c] = (mq[m*NCH + c].size() == DEPTH);
            a[c] = (mq[m*NCH + c].size() >= DEPTH - 2);
            o[c] = movf[m*NCH + c];
        end
        return {!mval[m], mdata[m], 1'(mch[m]), f, a, o};
    endfunction

    task automatic cycle();
        if (!rst) model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ce = 1'b0;
        wr_en = '0;
        rd_en = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({empty_r, data_r, ch_r, full_r, af_r, ovf_r} !== {1'b1, 32'h0, 1'b0, 6'h0}) begin
            bad++;
            $display("FAIL reset_rr: got %h want %h", {empty_r, data_r, ch_r, full_r, af_r, ovf_r}, {1'b1, 32'h0, 1'b0, 6'h0});
        end
        total++;
        if ({empty_f, data_f, ch_f, full_f, af_f, ovf_f} !== {1'b1, 32'h0, 1'b0, 6'h0}) begin
            bad++;
            $display("FAIL reset_fp: got %h want %h", {empty_f, data_f, ch_f, full_f, af_f, ovf_f}, {1'b1, 32'h0, 1'b0, 6'h0});
        end
        ce = 1'b1;
        wr_en = 2'b01;
        wr_data = '0;
        wr_data[31:0] = 32'hA1;
        cycle();
        wr_en = '0;
        total++;
        if (empty_r !== 1'b1) begin
            bad++;
            $display("FAIL push_not_yet_visible: got empty=%b want 1", empty_r);
        end
        cycle();
        total++;
        if ({empty_r, data_r, ch_r} !== {1'b0, 32'hA1, 1'b0}) begin
            bad++;
            $display("FAIL first_op: got %h want %h", {empty_r, data_r, ch_r}, {1'b0, 32'hA1, 1'b0});
        end
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        total++;
        if ({empty_r, data_r} !== {1'b1, 32'hA1}) begin
            bad++;
            $display("FAIL pop_to_empty: got %h want %h", {empty_r, data_r}, {1'b1, 32'hA1});
        end
    endtask

    task automatic test_arbitration_order();
        logic [DW-1:0] er [5];
        logic [DW-1:0] ef [5];
        er = '{32'h10, 32'h20, 32'h11, 32'h21, 32'h12};
        ef = '{32'h10, 32'h11, 32'h12, 32'h20, 32'h21};
        do_reset();
        ce = 1'b1;
        wr_en = 2'b11; wr_data = {32'h20, 32'h10}; cycle();
        wr_data = {32'h21, 32'h11}; cycle();
        wr_en = 2'b01; wr_data = {32'h0, 32'h12}; cycle();
        wr_en = '0;
        rd_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            total++;
            if ({empty_r, data_r, ch_r} !== {1'b0, er[k], 1'(er[k][5])}) begin
                bad++;
                $display("FAIL rr_order[%0d]: got %h want %h", k, {empty_r, data_r, ch_r}, {1'b0, er[k], 1'(er[k][5])});
            end
            total++;
            if ({empty_f, data_f, ch_f} !== {1'b0, ef[k], 1'(ef[k][5])}) begin
                bad++;
                $display("FAIL fp_order[%0d]: got %h want %h", k, {empty_f, data_f, ch_f}, {1'b0, ef[k], 1'(ef[k][5])});
            end
            cycle();
        end
        rd_en = 1'b0;
        total++;
        if ({empty_r, empty_f} !== 2'b11) begin
            bad++;
            $display("FAIL order_drained: got %b want 11", {empty_r, empty_f});
        end
    endtask

    task automatic test_overflow();
        int cnt;
        do_reset();
        ce = 1'b1;
        wr_en = 2'b10;
        for (int k = 1; k <= 17; k++) begin
            wr_data[63:32] = 32'h100 + k;
            cycle();
            // the output register absorbs the first op, so the FIFO holds one fewer than pushed
            cnt = (k == 1) ? 1 : k - 1;
            total++;
            if ({full_r[1], af_r[1]} !== {cnt == DEPTH, cnt >= DEPTH - 2}) begin
                bad++;
                $display("FAIL fill_flags[%0d]: got %b want %b", k, {full_r[1], af_r[1]}, {cnt == DEPTH, cnt >= DEPTH - 2});
            end
        end
        wr_data[63:32] = 32'hFF;
        cycle();
        wr_en = '0;
        total++;
        if ({full_r, ovf_r} !== 4'b1010) begin
            bad++;
            $display("FAIL overflow_set: got %b want 1010", {full_r, ovf_r});
        end
        rd_en = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            total++;
            if ({empty_r, data_r, ch_r} !== {1'b0, 32'h100 + k, 1'b1}) begin
                bad++;
                $display("FAIL drain[%0d]: got %h want %h", k, {empty_r, data_r, ch_r}, {1'b0, 32'h100 + k, 1'b1});
            end
            cycle();
        end
        rd_en = 1'b0;
        total++;
        if ({empty_r, full_r, ovf_r} !== 5'b1_00_10) begin
            bad++;
            $display("FAIL overflow_sticky: got %b want 10010", {empty_r, full_r, ovf_r});
        end
    endtask

    task automatic test_clock_enable();
        do_reset();
        ce = 1'b1;
        wr_en = 2'b11;
        for (int k = 0; k < 3; k++) begin
            wr_data = {$urandom, $urandom};
            cycle();
        end
        wr_en = '0;
        cycle();
        for (int k = 0; k < 9; k++) begin
            ce = (k >= 3);
            wr_en = (k < 3) ? 2'b11 : 2'b00;
            rd_en = 1'b1;
            wr_data = {$urandom, $urandom};
            cycle();
            total++;
            if ({empty_r, data_r, ch_r, full_r, af_r, ovf_r} !== exp_vec(0)) begin
                bad++;
                $display("FAIL ce_rr[%0d]: got %h want %h", k, {empty_r, data_r, ch_r, full_r, af_r, ovf_r}, exp_vec(0));
            end
            total++;
            if ({empty_f, data_f, ch_f, full_f, af_f, ovf_f} !== exp_vec(1)) begin
                bad++;
                $display("FAIL ce_fp[%0d]: got %h want %h", k, {empty_f, data_f, ch_f, full_f, af_f, ovf_f}, exp_vec(1));
            end
        end
        rd_en = 1'b0;
        ce = 1'b1;
    endtask

    task automatic test_async_reset();
        do_reset();
        ce = 1'b1;
        wr_en = 2'b10;
        for (int k = 1; k <= 18; k++) begin
            wr_data[63:32] = 32'h200 + k;
            cycle();
        end
        wr_en = '0;
        rd_en = 1'b1;
        for (int k = 0; k < 12; k++) cycle();
        rd_en = 1'b0;
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        total++;
        if ({empty_r, full_r, af_r, ovf_r, empty_f, full_f, ovf_f} !== {1'b1, 6'h0, 1'b1, 4'h0}) begin
            bad++;
            $display("FAIL async_reset: got %b want %b", {empty_r, full_r, af_r, ovf_r, empty_f, full_f, ovf_f}, {1'b1, 6'h0, 1'b1, 4'h0});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        wr_en = 2'b01;
        wr_data = {32'h0, 32'h55};
        cycle();
        wr_en = '0;
        cycle();
        total++;
        if ({empty_r, data_r, ch_r} !== {1'b0, 32'h55, 1'b0}) begin
            bad++;
            $display("FAIL post_reset_first: got %h want %h", {empty_r, data_r, ch_r}, {1'b0, 32'h55, 1'b0});
        end
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        total++;
        if (empty_r !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_discard: got empty=%b want 1", empty_r);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            ce = ($urandom_range(0, 9) != 0);
            wr_en = NCH'($urandom);
            wr_data = {$urandom, $urandom};
            rd_en = ((n / 100) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            cycle();
            total++;
            if ({empty_r, data_r, ch_r, full_r, af_r, ovf_r} !== exp_vec(0)) begin
                bad++;
                $display("FAIL rand_rr[%0d]: got %h want %h", n, {empty_r, data_r, ch_r, full_r, af_r, ovf_r}, exp_vec(0));
            end
            total++;
            if ({empty_f, data_f, ch_f, full_f, af_f, ovf_f} !== exp_vec(1)) begin
                bad++;
                $display("FAIL rand_fp[%0d]: got %h want %h", n, {empty_f, data_f, ch_f, full_f, af_f, ovf_f}, exp_vec(1));
            end
        end
        wr_en = '0;
        rd_en = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_arbitration_order();
        test_overflow();
        test_clock_enable();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
